// File: rtl/dma_bus_responder_pkg.sv
// dma_bus_responder_pkg: shared bus widths, region limit and arbiter state encodings.
`default_nettype none

package dma_bus_responder_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;
    localparam logic [BUS_ADDR_W-1:0] BUS_SLV_LIMIT = 8'h20;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/dma_bus_ram.sv
// dma_bus_ram: single-port word RAM, synchronous write, registered read that holds between reads.
`default_nettype none

module dma_bus_ram
    import dma_bus_responder_pkg::*;
#(
    parameter int AW = BUS_ADDR_W,
    parameter int DW = BUS_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];

    // Array kept free of reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem_q[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_bus_responder.sv
// dma_bus_responder: two-master fixed-priority arbiter with slave-window / RAM decode and 1-cycle reads.
`default_nettype none

module dma_bus_responder
    import dma_bus_responder_pkg::*;
#(
    parameter int                ADDR_W    = BUS_ADDR_W,
    parameter int                DATA_W    = BUS_DATA_W,
    parameter logic [ADDR_W-1:0] SLV_LIMIT = BUS_SLV_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    output logic              M0_grant,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M_din,
    output logic              S_sel,
    output logic              S_wr,
    output logic [ADDR_W-1:0] S_address,
    output logic [DATA_W-1:0] S_din,
    input  logic [DATA_W-1:0] S_dout
);

    logic [1:0]        state_q, state_d;
    logic              bus_req, bus_wr, access, slv_hit;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data, ram_dout;
    logic              rsel_q, rsel_d;

    // No preemption: the owner keeps the bus until its own request drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (M0_req)      state_d = ST_GNT0;
                else if (M1_req) state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (M0_req)      state_d = ST_GNT0;
                else if (M1_req) state_d = ST_GNT1;
                else             state_d = ST_IDLE;
            end
            ST_GNT1: begin
                if (M1_req)      state_d = ST_GNT1;
                else if (M0_req) state_d = ST_GNT0;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign M0_grant = (state_q == ST_GNT0);
    assign M1_grant = (state_q == ST_GNT1);

    assign bus_req  = M1_grant ? M1_req     : M0_req;
    assign bus_wr   = M1_grant ? M1_wr      : M0_wr;
    assign bus_addr = M1_grant ? M1_address : M0_address;
    assign bus_data = M1_grant ? M1_dout    : M0_dout;

    // Reset forces IDLE asynchronously, so an interrupted transfer never writes.
    assign access  = (state_q != ST_IDLE) && bus_req;
    assign slv_hit = (bus_addr < SLV_LIMIT);

    assign S_sel     = access && slv_hit;
    assign S_wr      = access && slv_hit && bus_wr;
    assign S_address = bus_addr;
    assign S_din     = bus_data;

    dma_bus_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk  (clk),
        .rst  (reset),
        .we   (access && bus_wr && !slv_hit),
        .re   (access && !bus_wr && !slv_hit),
        .addr (bus_addr),
        .din  (bus_data),
        .dout (ram_dout)
    );

    // Only reads move the source select, so M_din holds between reads.
    assign rsel_d = (access && !bus_wr) ? slv_hit : rsel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsel_q <= 1'b0;
        end else begin
            rsel_q <= rsel_d;
        end
    end

    assign M_din = rsel_q ? S_dout : ram_dout;

endmodule

`default_nettype wire

// File: tb/tb_dma_bus_responder.sv
// tb_dma_bus_responder: randomized two-master traffic checked by a queue scoreboard against a reference memory.
`default_nettype none

module tb_dma_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant;
    logic [31:0] M_din;
    logic        S_sel, S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout = '0;

    always #5 clk = ~clk;

    dma_bus_responder dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M0_wr      (M0_wr),
        .M0_address (M0_address),
        .M0_dout    (M0_dout),
        .M0_grant   (M0_grant),
        .M1_req     (M1_req),
        .M1_wr      (M1_wr),
        .M1_address (M1_address),
        .M1_dout    (M1_dout),
        .M1_grant   (M1_grant),
        .M_din      (M_din),
        .S_sel      (S_sel),
        .S_wr       (S_wr),
        .S_address  (S_address),
        .S_din      (S_din),
        .S_dout     (S_dout)
    );

    // Behaviour of the DMAC slave register file: registered read data.
    logic [31:0] slv_mem [0:31] = '{default: 32'h0};
    always @(posedge clk) begin
        if (S_sel && S_wr)  slv_mem[S_address[4:0]] <= S_din;
        if (S_sel && !S_wr) S_dout <= slv_mem[S_address[4:0]];
    end

    // Reference view of the whole address map, both regions.
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q [$];
    int          owner = -1;
    bit          rd_fire = 1'b0;
    bit          exp_ssel = 1'b0, exp_swr = 1'b0;
    logic [7:0]  exp_saddr = '0;
    logic [31:0] exp_sdin = '0;
    bit          done = 1'b0;
    int          tmo = 0;
    int          n_chk = 0, n_fail = 0;

    function automatic logic [7:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 8'h1F;
        if (k == 1) return 8'h20;
        return 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3));
    endfunction

    task automatic cycle(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                         input bit abort, output bit acc);
        logic       w;
        logic [7:0] a;
        logic [31:0] d;
        @(negedge clk);
        M0_req = r0; M0_wr = w0; M0_address = a0; M0_dout = d0;
        M1_req = r1; M1_wr = w1; M1_address = a1; M1_dout = d1;
        w = (owner == 1) ? w1 : w0;
        a = (owner == 1) ? a1 : a0;
        d = (owner == 1) ? d1 : d0;
        acc = (owner == 0 && r0) || (owner == 1 && r1);
        exp_ssel  = acc && (a < 8'h20);
        exp_swr   = exp_ssel && w;
        exp_saddr = a;
        exp_sdin  = d;
        rd_fire   = acc && !w && !abort;
        if (acc && !abort) begin
            if (w) ref_mem[a] = d;
            else   exp_q.push_back(ref_mem[a]);
        end
        if (abort) begin
            #3 reset = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks decode outputs, grants and the read-data scoreboard every cycle.
    always begin : monitor
        bit          fire;
        logic [31:0] last;
        @(negedge clk);
        #2;
        chk("S_sel", 32'(S_sel), 32'(exp_ssel));
        chk("S_wr", 32'(S_wr), 32'(exp_swr));
        if (exp_ssel) begin
            chk("S_address", 32'(S_address), 32'(exp_saddr));
            chk("S_din", S_din, exp_sdin);
        end
        #2;
        if (reset) begin
            chk("rst_M0_grant", 32'(M0_grant), 32'h0);
            chk("rst_M1_grant", 32'(M1_grant), 32'h0);
            chk("rst_M_din", M_din, 32'h0);
            chk("rst_S_sel", 32'(S_sel), 32'h0);
        end
        @(posedge clk);
        fire = rd_fire;
        if (reset)            owner = -1;
        else if (owner == 1)  owner = M1_req ? 1 : (M0_req ? 0 : -1);
        else if (owner == 0)  owner = M0_req ? 0 : (M1_req ? 1 : -1);
        else                  owner = M0_req ? 0 : (M1_req ? 1 : -1);
        #1;
        chk("M0_grant", 32'(M0_grant), 32'(owner == 0));
        chk("M1_grant", 32'(M1_grant), 32'(owner == 1));
        if (reset) begin
            last = '0;
        end else if (fire) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 32'h1, 32'h0);
            else                   last = exp_q.pop_front();
        end
        chk("M_din", M_din, last);
        if (done) begin
            chk("queue_drained", 32'(exp_q.size()), 32'h0);
            chk("timeouts", 32'(tmo), 32'h0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin : driver
        bit acc;
        bit r0, r1;
        int i, n;
        reset = 1'b1;
        M0_req = 0; M0_wr = 0; M0_address = '0; M0_dout = '0;
        M1_req = 0; M1_wr = 0; M1_address = '0; M1_dout = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Fill the whole map so every later read has a known value.
        i = 0; n = 0;
        while (i < 256 && n < 400) begin
            cycle(1, 1, 8'(i), $urandom, 0, 0, 8'h0, 32'h0, 0, acc);
            if (acc) i++;
            n++;
        end
        if (i < 256) tmo++;

        cycle(1, 1, 8'h40, 32'hDEADBEEF, 0, 0, 8'h0, 32'h0, 0, acc);
        cycle(1, 0, 8'h40, 32'h0,        0, 0, 8'h0, 32'h0, 0, acc);
        cycle(1, 1, 8'h04, 32'h12345678, 0, 0, 8'h0, 32'h0, 0, acc);
        cycle(1, 1, 8'h00, 32'h00000001, 0, 0, 8'h0, 32'h0, 0, acc);
        cycle(1, 0, 8'h04, 32'h0,        0, 0, 8'h0, 32'h0, 0, acc);
        cycle(0, 0, 8'h0,  32'h0,        0, 0, 8'h0, 32'h0, 0, acc);
        cycle(0, 0, 8'h0,  32'h0,        0, 0, 8'h0, 32'h0, 0, acc);

        // Simultaneous requests, handover to M1, DMAC copy 0x40 -> 0x80, host readback.
        cycle(1, 0, 8'h40, 32'h0,       1, 0, 8'h40, 32'h0,        0, acc);
        cycle(1, 1, 8'h44, $urandom,    1, 0, 8'h40, 32'h0,        0, acc);
        cycle(0, 0, 8'h0,  32'h0,       1, 0, 8'h40, 32'h0,        0, acc);
        cycle(0, 0, 8'h0,  32'h0,       1, 0, 8'h40, 32'h0,        0, acc);
        cycle(0, 0, 8'h0,  32'h0,       1, 1, 8'h80, 32'hDEADBEEF, 0, acc);
        cycle(1, 0, 8'h80, 32'h0,       0, 0, 8'h0,  32'h0,        0, acc);
        cycle(1, 0, 8'h80, 32'h0,       0, 0, 8'h0,  32'h0,        0, acc);

        r0 = 1'b1; r1 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r0 = r0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
            r1 = r1 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
            cycle(r0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                  r1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 0, acc);
        end

        // Reset in the middle of a DMAC write to RAM; the old word must survive.
        n = 0;
        do begin
            cycle(0, 0, 8'h0, 32'h0, 1, 0, 8'h90, 32'h0, 0, acc);
            n++;
        end while (owner != 1 && n < 50);
        if (owner != 1) tmo++;
        cycle(0, 0, 8'h0, 32'h0, 1, 1, 8'h90, 32'hCAFEF00D, 1, acc);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            cycle(1, 0, 8'h90, 32'h0, 0, 0, 8'h0, 32'h0, 0, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) tmo++;

        repeat (3) cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0, acc);
        done = 1'b1;
    end

endmodule

`default_nettype wire

// File: doc/dma_bus_responder.md
Name: dma_bus_responder

Overview:
- Bus-side counterpart to the DMA controller's master port: arbitrates between the host master (M0) and the DMAC master (M1), then responds to the granted master's transfers.
- Decodes each address to either the DMAC slave register window or an internal word RAM.
- Returns read data with fixed one-cycle latency.
- Sits between the testbench/host, the DMAC master port and the DMAC slave port at system top level.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 32, bus data width.
- SLV_LIMIT, 8'h20, addresses below this value select the DMAC slave register window; all others select RAM.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- M0_req  in  1  host bus request
- M0_wr  in  1  host write(1)/read(0)
- M0_address  in  ADDR_W  host address
- M0_dout  in  DATA_W  host write data
- M0_grant  out  1  host grant
- M1_req  in  1  DMAC bus request (DMAC M_req)
- M1_wr  in  1  DMAC write/read (DMAC M_wr)
- M1_address  in  ADDR_W  DMAC address (DMAC M_address)
- M1_dout  in  DATA_W  DMAC write data (DMAC M_dout)
- M1_grant  out  1  DMAC grant (DMAC M_grant)
- M_din  out  DATA_W  shared read data to both masters
- S_sel  out  1  DMAC slave select
- S_wr  out  1  DMAC slave write/read
- S_address  out  ADDR_W  DMAC slave address
- S_din  out  DATA_W  DMAC slave write data
- S_dout  in  DATA_W  DMAC slave read data, registered by the slave, valid one cycle after a read select

Behaviour:
- Arbiter FSM states: IDLE, GNT0, GNT1, state register 2 bits.
  - IDLE: if M0_req, go to GNT0; else if M1_req, go to GNT1. M0 has fixed priority.
  - GNT0: stay while M0_req=1. If M0_req=0 and M1_req=1, go to GNT1. Otherwise go to IDLE.
  - GNT1: stay while M1_req=1. If M1_req=0 and M0_req=1, go to GNT0. Otherwise go to IDLE.
  - No preemption: an active grant is held until its own request drops.
- Grant timing: grants are Moore outputs of the state register. Grant rises one cycle after req is sampled and falls one cycle after req drops.
- Bus mux: selected master is M1 in GNT1, otherwise M0. The selected master's wr/address/dout drive the internal bus.
- Access valid: access = (state != IDLE) && selected master's req. No access ever occurs in IDLE.
- Decode:
  - address < SLV_LIMIT: slave region.
    - S_sel = access.
    - S_wr = access & wr.
    - S_address and S_din are the muxed bus values, driven combinationally.
  - Otherwise: RAM region. RAM is 256 x DATA_W words, indexed by the full address; entries 0x00-0x1F are unreachable.
- Writes: RAM is written on the clock edge where access & wr & RAM region. Data is visible to a read in the following cycle.
- Reads:
  - RAM read data is registered: rd_q <= ram[address] on any access with wr=0 to the RAM region.
  - The region of each access is registered as rsel_q.
  - M_din = rsel_q ? S_dout : rd_q.
  - Read latency is exactly 1 cycle for both regions.
  - M_din holds its last value when there is no read.
- Simultaneous requests from IDLE: M0 wins. M1 waits until M0_req drops, then M1_grant rises one cycle later with no IDLE gap.
- Read-after-write to the same RAM address in back-to-back cycles returns the new data.
- Reset (asynchronous, valid at any time, including mid-transfer):
  - state=IDLE, M0_grant=0, M1_grant=0, rd_q=0, rsel_q=0, so M_din=0 and S_sel=0.
  - RAM contents are not reset.
  - A transfer interrupted by reset is dropped, with no partial write.
- Grant is never asserted to both masters. Exactly one or none is asserted at all times.

Decomposition:
- Shared package: arbiter state encodings (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10), SLV_LIMIT, ADDR_W, DATA_W.
- One sub-module: dma_bus_ram, a 256 x DATA_W synchronous-write, registered-read single-port RAM with ports clk, we, addr, din, dout.
- Arbiter FSM and decode stay in the top module.

Test Plan:
1. Reset, then M0_req=1 at cycle 2 -> M0_grant=1 at cycle 3, M1_grant=0, M_din=0 throughout reset.
2. M0 writes 32'hDEADBEEF to 8'h40, then reads 8'h40 -> M_din=32'hDEADBEEF one cycle after the read address is presented.
3. M0_req and M1_req rise in the same cycle -> M0_grant first. M0_req drops at cycle N -> M0_grant=0 and M1_grant=1 at cycle N+1.
4. M0 writes 32'h00000001 to 8'h00 -> S_sel=1, S_wr=1, S_address=8'h00, S_din=32'h1 in that cycle. Reading 8'h04 with S_dout=32'h12345678 returns M_din=32'h12345678 after one cycle.
5. DMAC reads 8'h40 and writes 8'h80 in consecutive granted cycles -> ram[8'h80]=32'hDEADBEEF; an M0 readback of 8'h80 confirms it.
6. Assert reset mid-write while M1_grant=1 -> grants drop immediately, state is IDLE, and the target RAM word is unchanged on readback.
